cos_lut_arbiter: RTL and testbench

- Shares one cosine_lut read port between NUM_REQ requesters: modulator NCO I, NCO Q, carrier-recovery loop and test/debug.
- Each cycle it round-robin arbitrates requests and drives the granted phase onto the LUT.
- It carries a requester tag through a delay line matched to the LUT latency, then routes the returned 18-bit sample back to the originating requester.
- An optional sine mode per request rotates the phase by -90° so one cosine table also serves sine.

---
 rtl/cos_lut_arbiter.sv | 116 +++++++++++
 tb/tb_cos_lut_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cos_lut_arbiter.sv
// cos_lut_arbiter: round-robin sharing of one cosine_lut read port, with tag-matched response routing.
// Build option COS_ARB_PRIO0_EN: requester 0 gets fixed priority over a round-robin of the others.
module cos_lut_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PHASE_W     = 9,
  parameter int DATA_W      = 18,
  parameter int LUT_LATENCY = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*PHASE_W-1:0] req_phase,
  input  logic [NUM_REQ-1:0]         req_sin,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [PHASE_W-1:0]         lut_phase,
  input  logic signed [DATA_W-1:0]   lut_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic signed [DATA_W-1:0]   rsp_data
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(1) << (PHASE_W - 2);
`ifdef COS_ARB_PRIO0_EN
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(1);
`else
  localparam logic [IDX_W-1:0] PTR_INIT = '0;
`endif

  // sin(x) = cos(x - 90deg); the subtraction wraps around the full period
  function automatic logic [PHASE_W-1:0] rotate_phase(input logic [PHASE_W-1:0] phase,
                                                       input logic sin_mode);
    return sin_mode ? phase - QUARTER : phase;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) return PTR_INIT;
    return idx + IDX_W'(1);
  endfunction

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_any;
  logic             accept;

  logic             tag_vld_p [LUT_LATENCY+1];
  logic [IDX_W-1:0] tag_idx_p [LUT_LATENCY+1];

  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
`ifdef COS_ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_any = 1'b1;
    end else begin
      // pointer lives in 1..NUM_REQ-1, so the rotation skips requester 0
      for (int off = 0; off < NUM_REQ - 1; off++) begin
        cand = IDX_W'(1 + ((int'(ptr) - 1 + off) % (NUM_REQ - 1)));
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
`else
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
`endif
  end

  assign accept    = grant_any & rst_n;
  assign req_ready = accept ? onehot(grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= PTR_INIT;
      lut_phase <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int i = 0; i <= LUT_LATENCY; i++) tag_vld_p[i] <= 1'b0;
    end else begin
      // stage 0: address and tag launched together on the accept edge
      if (accept) begin
        lut_phase <= rotate_phase(req_phase[grant_idx*PHASE_W +: PHASE_W], req_sin[grant_idx]);
`ifdef COS_ARB_PRIO0_EN
        if (grant_idx != '0) ptr <= next_ptr(grant_idx);
`else
        ptr <= next_ptr(grant_idx);
`endif
      end
      tag_vld_p[0] <= accept;
      tag_idx_p[0] <= grant_idx;
      // stages 1..LUT_LATENCY: tag tracks the address through the LUT pipeline
      for (int i = 1; i <= LUT_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_idx_p[i] <= tag_idx_p[i-1];
      end
      // response stage: sample pairs with the tag leaving the last stage
      rsp_valid <= tag_vld_p[LUT_LATENCY] ? onehot(tag_idx_p[LUT_LATENCY]) : '0;
      if (tag_vld_p[LUT_LATENCY]) rsp_data <= lut_data;
    end
  end
endmodule

// File: tb/tb_cos_lut_arbiter.sv
// Directed bench for cos_lut_arbiter: two instances (LUT latency 0 and 3) share one stimulus.
module tb_cos_lut_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [3:0]         req_valid;
  logic [35:0]        req_phase;
  logic [3:0]         req_sin;
  logic [3:0]         ready0, ready3, rsp_valid0, rsp_valid3;
  logic [8:0]         lut_phase0, lut_phase3;
  logic signed [17:0] lut_data0, lut_data3, rsp_data0, rsp_data3;
  logic signed [17:0] d1, d2, d3;
  int errors = 0;
  int checks = 0;

  int         k_t [6] = '{1, 3, 0, 2, 1, 3};
  logic [8:0] p_t [6] = '{9'h1FF, 9'h000, 9'h0C0, 9'h07F, 9'h100, 9'h1FF};
  logic       s_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [8:0] e_t [6] = '{9'h1FF, 9'h180, 9'h0C0, 9'h1FF, 9'h080, 9'h17F};

  cos_lut_arbiter #(.NUM_REQ(4), .PHASE_W(9), .DATA_W(18), .LUT_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_phase(req_phase), .req_sin(req_sin),
    .req_ready(ready0), .lut_phase(lut_phase0), .lut_data(lut_data0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0));

  cos_lut_arbiter #(.NUM_REQ(4), .PHASE_W(9), .DATA_W(18), .LUT_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_phase(req_phase), .req_sin(req_sin),
    .req_ready(ready3), .lut_phase(lut_phase3), .lut_data(lut_data3),
    .rsp_valid(rsp_valid3), .rsp_data(rsp_data3));

  function automatic logic signed [17:0] cos_ref(input logic [8:0] p);
    real x;
    x = 131071.0 * $cos(6.283185307179586 * real'(p) / 512.0);
    return 18'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
  endfunction

  always_comb lut_data0 = cos_ref(lut_phase0);
  always @(posedge clk) begin
    d1 <= cos_ref(lut_phase3);
    d2 <= d1;
    d3 <= d2;
  end
  assign lut_data3 = d3;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input int k, input logic [8:0] p, input logic s);
    req_valid = v;
    req_phase = 36'({$urandom(), $urandom()});
    req_phase[k*9 +: 9] = p;
    req_sin = 4'($urandom());
    req_sin[k] = s;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 4'hF; req_phase = '0; req_sin = '0;
    tick; tick;
    checks++; if (ready0 !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", ready0); end
    checks++; if (lut_phase0 !== 9'h000 || lut_phase3 !== 9'h000) begin errors++; $display("FAIL reset_lut_phase got=%h/%h exp=000", lut_phase0, lut_phase3); end
    checks++; if (rsp_valid0 !== 4'b0000 || rsp_valid3 !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b/%b exp=0000", rsp_valid0, rsp_valid3); end
    checks++; if (rsp_data0 !== 18'sd0 || rsp_data3 !== 18'sd0) begin errors++; $display("FAIL reset_rsp_data got=%h/%h exp=0", rsp_data0, rsp_data3); end
    rst_n = 1'b1; req_valid = 4'h0;
  endtask

  task automatic test_single;
    tick;
    drive(4'b0001, 0, 9'h000, 1'b0);
    #1;
    checks++; if (ready0 !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", ready0); end
    tick; req_valid = 4'h0;
    checks++; if (lut_phase0 !== 9'h000) begin errors++; $display("FAIL single_lut_phase got=%h exp=000", lut_phase0); end
    checks++; if (rsp_valid0 !== 4'b0000) begin errors++; $display("FAIL single_early_rsp got=%b exp=0000", rsp_valid0); end
    tick;
    checks++; if (rsp_valid0 !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid0); end
    checks++; if (rsp_data0 !== 18'sh1FFFF) begin errors++; $display("FAIL single_rsp_data got=%h exp=1ffff", rsp_data0); end
    tick;
    checks++; if (rsp_valid0 !== 4'b0000) begin errors++; $display("FAIL single_pulse got=%b exp=0000", rsp_valid0); end
    checks++; if (rsp_data0 !== 18'sh1FFFF) begin errors++; $display("FAIL single_hold got=%h exp=1ffff", rsp_data0); end
  endtask

  task automatic test_sine;
    tick;
    drive(4'b0100, 2, 9'h050, 1'b1);
    #1;
    checks++; if (ready0 !== 4'b0100) begin errors++; $display("FAIL sine_ready1 got=%b exp=0100", ready0); end
    tick;
    drive(4'b0100, 2, 9'h080, 1'b1);
    checks++; if (lut_phase0 !== 9'h1D0) begin errors++; $display("FAIL sine_wrap_phase got=%h exp=1d0", lut_phase0); end
    #1;
    checks++; if (ready0 !== 4'b0100) begin errors++; $display("FAIL sine_ready2 got=%b exp=0100", ready0); end
    tick; req_valid = 4'h0;
    checks++; if (lut_phase0 !== 9'h000) begin errors++; $display("FAIL sine_zero_phase got=%h exp=000", lut_phase0); end
    checks++; if (rsp_valid0 !== 4'b0100) begin errors++; $display("FAIL sine_rsp1 got=%b exp=0100", rsp_valid0); end
    checks++; if (rsp_data0 !== cos_ref(9'h1D0)) begin errors++; $display("FAIL sine_data1 got=%h exp=%h", rsp_data0, cos_ref(9'h1D0)); end
    tick;
    checks++; if (rsp_valid0 !== 4'b0100) begin errors++; $display("FAIL sine_rsp2 got=%b exp=0100", rsp_valid0); end
    checks++; if (rsp_data0 !== 18'sh1FFFF) begin errors++; $display("FAIL sine_data2 got=%h exp=1ffff", rsp_data0); end
  endtask

  task automatic test_reset_midflight;
    logic [3:0] exp_g [3] = '{4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      tick;
      req_valid = 4'hF; req_phase = {9'h031, 9'h021, 9'h011, 9'h001}; req_sin = 4'h0;
      #1;
      checks++; if (ready0 !== exp_g[i]) begin errors++; $display("FAIL midflight_grant%0d got=%b exp=%b", i, ready0, exp_g[i]); end
    end
    tick; rst_n = 1'b0;
    #1;
    checks++; if (ready0 !== 4'b0000) begin errors++; $display("FAIL midflight_ready_in_reset got=%b exp=0000", ready0); end
    tick; rst_n = 1'b1; req_valid = 4'h0;
    checks++; if (lut_phase0 !== 9'h000 || lut_phase3 !== 9'h000) begin errors++; $display("FAIL midflight_lut_phase got=%h/%h exp=000", lut_phase0, lut_phase3); end
    checks++; if (rsp_data0 !== 18'sd0 || rsp_data3 !== 18'sd0) begin errors++; $display("FAIL midflight_rsp_data got=%h/%h exp=0", rsp_data0, rsp_data3); end
    for (int i = 0; i < 7; i++) begin
      checks++; if ({rsp_valid0, rsp_valid3} !== 8'h00) begin errors++; $display("FAIL midflight_stale_rsp%0d got=%b/%b exp=0000", i, rsp_valid0, rsp_valid3); end
      tick;
    end
    req_valid = 4'hF;
    #1;
    checks++; if (ready0 !== 4'b0001) begin errors++; $display("FAIL midflight_next_grant got=%b exp=0001", ready0); end
    req_valid = 4'h0;
  endtask

  task automatic test_fairness;
    for (int i = 0; i < 14; i++) begin
      tick;
      if (i >= 1 && i <= 8) begin
        checks++; if (lut_phase0 !== 9'(16 * ((i - 1) % 4))) begin errors++; $display("FAIL fair_phase%0d got=%h exp=%h", i, lut_phase0, 9'(16 * ((i - 1) % 4))); end
      end
      if (i >= 2 && i <= 9) begin
        checks++; if (rsp_valid0 !== 4'(1) << ((i - 2) % 4)) begin errors++; $display("FAIL fair_rsp0_%0d got=%b exp=%b", i, rsp_valid0, 4'(1) << ((i - 2) % 4)); end
        checks++; if (rsp_data0 !== cos_ref(9'(16 * ((i - 2) % 4)))) begin errors++; $display("FAIL fair_data0_%0d got=%h exp=%h", i, rsp_data0, cos_ref(9'(16 * ((i - 2) % 4)))); end
      end else begin
        checks++; if (rsp_valid0 !== 4'b0000) begin errors++; $display("FAIL fair_idle0_%0d got=%b exp=0000", i, rsp_valid0); end
      end
      if (i >= 5 && i <= 12) begin
        checks++; if (rsp_valid3 !== 4'(1) << ((i - 5) % 4)) begin errors++; $display("FAIL fair_rsp3_%0d got=%b exp=%b", i, rsp_valid3, 4'(1) << ((i - 5) % 4)); end
        checks++; if (rsp_data3 !== cos_ref(9'(16 * ((i - 5) % 4)))) begin errors++; $display("FAIL fair_data3_%0d got=%h exp=%h", i, rsp_data3, cos_ref(9'(16 * ((i - 5) % 4)))); end
      end else begin
        checks++; if (rsp_valid3 !== 4'b0000) begin errors++; $display("FAIL fair_idle3_%0d got=%b exp=0000", i, rsp_valid3); end
      end
      if (i < 8) begin
        req_valid = 4'hF; req_phase = {9'h030, 9'h020, 9'h010, 9'h000}; req_sin = 4'h0;
        #1;
        checks++; if (ready0 !== 4'(1) << (i % 4) || ready3 !== 4'(1) << (i % 4)) begin errors++; $display("FAIL fair_grant%0d got=%b/%b exp=%b", i, ready0, ready3, 4'(1) << (i % 4)); end
      end else begin
        req_valid = 4'h0;
      end
    end
  endtask

  task automatic test_latency3;
    req_valid = 4'h0;
    repeat (6) tick;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (i >= 1 && i <= 6) begin
        checks++; if (lut_phase3 !== e_t[i-1]) begin errors++; $display("FAIL lat_phase%0d got=%h exp=%h", i, lut_phase3, e_t[i-1]); end
      end
      if (i >= 2 && i <= 7) begin
        checks++; if (rsp_valid0 !== 4'(1) << k_t[i-2] || rsp_data0 !== cos_ref(e_t[i-2])) begin errors++; $display("FAIL lat0_rsp%0d got=%b/%h exp=%b/%h", i, rsp_valid0, rsp_data0, 4'(1) << k_t[i-2], cos_ref(e_t[i-2])); end
      end else begin
        checks++; if (rsp_valid0 !== 4'b0000) begin errors++; $display("FAIL lat0_idle%0d got=%b exp=0000", i, rsp_valid0); end
      end
      if (i >= 5 && i <= 10) begin
        checks++; if (rsp_valid3 !== 4'(1) << k_t[i-5] || rsp_data3 !== cos_ref(e_t[i-5])) begin errors++; $display("FAIL lat3_rsp%0d got=%b/%h exp=%b/%h", i, rsp_valid3, rsp_data3, 4'(1) << k_t[i-5], cos_ref(e_t[i-5])); end
      end else begin
        checks++; if (rsp_valid3 !== 4'b0000) begin errors++; $display("FAIL lat3_idle%0d got=%b exp=0000", i, rsp_valid3); end
      end
      if (i < 6) begin
        drive(4'(1) << k_t[i], k_t[i], p_t[i], s_t[i]);
        #1;
        checks++; if (ready3 !== 4'(1) << k_t[i]) begin errors++; $display("FAIL lat_grant%0d got=%b exp=%b", i, ready3, 4'(1) << k_t[i]); end
      end else begin
        req_valid = 4'h0;
      end
    end
  endtask

`ifdef COS_ARB_PRIO0_EN
  task automatic test_prio0;
    logic [3:0] exp_g [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    tick; rst_n = 1'b0; req_valid = 4'h0;
    tick; rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      req_valid = 4'hF; req_phase = {9'h030, 9'h020, 9'h010, 9'h000}; req_sin = 4'h0;
      #1;
      checks++; if (ready0 !== 4'b0001) begin errors++; $display("FAIL prio0_grant%0d got=%b exp=0001", i, ready0); end
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      req_valid = 4'b1110;
      #1;
      checks++; if (ready0 !== exp_g[i]) begin errors++; $display("FAIL prio_rr_grant%0d got=%b exp=%b", i, ready0, exp_g[i]); end
    end
    tick; req_valid = 4'h0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_sine;
`ifndef COS_ARB_PRIO0_EN
    test_reset_midflight;
    test_fairness;
`endif
    test_latency3;
`ifdef COS_ARB_PRIO0_EN
    test_prio0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
